// File: rtl/wash_cycle_scheduler.sv
// Washing-machine cycle scheduler: BCD set/remaining time, forward/pause/
// backward/pause motor sequencing, completion alarm and emergency halt/resume.
module wash_cycle_scheduler #(
    parameter int unsigned RUN_T   = 20,
    parameter int unsigned PAUSE_T = 10,
    parameter int unsigned ALARM_T = 5
) (
    input  logic       CLK_50,
    input  logic       CLR,
    input  logic       tick,
    input  logic       add,
    input  logic       start,
    input  logic       emergency,
    output logic       forward,
    output logic       backward,
    output logic       off,
    output logic       alarm,
    output logic [7:0] remain_bcd,
    output logic       busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_P1   = 3'd2;
    localparam logic [2:0] S_BWD  = 3'd3;
    localparam logic [2:0] S_P2   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    logic [2:0] state_q, state_nxt, saved_q, saved_nxt;
    logic [7:0] set_q, set_nxt, rem_q, rem_nxt;
    logic [7:0] seg_q, seg_nxt, alm_q, alm_nxt;
    logic [7:0] seg_len;
    logic       add_q, start_q;
    logic       add_edge, start_edge, running;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
        else                r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    assign add_edge   = add & ~add_q;
    assign start_edge = start & ~start_q;
    assign running    = (state_q == S_FWD) || (state_q == S_P1) ||
                        (state_q == S_BWD) || (state_q == S_P2);
    assign seg_len    = ((state_q == S_FWD) || (state_q == S_BWD)) ? 8'(RUN_T) : 8'(PAUSE_T);

    // Next-state, counters and set/remaining time
    always_comb begin
        state_nxt = state_q;
        saved_nxt = saved_q;
        set_nxt   = set_q;
        rem_nxt   = rem_q;
        seg_nxt   = seg_q;
        alm_nxt   = alm_q;
        case (state_q)
            S_IDLE: begin
                if (add_edge) set_nxt = bcd_inc(set_q);
                // start latches the value shown before any same-cycle add
                if (start_edge && emergency && set_q != 8'h00) begin
                    state_nxt = S_FWD;
                    rem_nxt   = set_q;
                    seg_nxt   = 8'd0;
                end
            end
            S_FWD, S_P1, S_BWD, S_P2: begin
                // emergency takes priority; a same-cycle tick is dropped
                if (!emergency) begin
                    state_nxt = S_HALT;
                    saved_nxt = state_q;
                end else if (tick) begin
                    rem_nxt = bcd_dec(rem_q);
                    if (rem_q == 8'h01) begin
                        state_nxt = S_DONE;
                        seg_nxt   = 8'd0;
                        alm_nxt   = 8'd0;
                    end else if (seg_q + 8'd1 == seg_len) begin
                        seg_nxt = 8'd0;
                        case (state_q)
                            S_FWD:   state_nxt = S_P1;
                            S_P1:    state_nxt = S_BWD;
                            S_BWD:   state_nxt = S_P2;
                            default: state_nxt = S_FWD;
                        endcase
                    end else begin
                        seg_nxt = seg_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                if (tick) begin
                    if (alm_q + 8'd1 == 8'(ALARM_T)) begin
                        state_nxt = S_IDLE;
                        alm_nxt   = 8'd0;
                    end else begin
                        alm_nxt = alm_q + 8'd1;
                    end
                end
            end
            S_HALT: begin
                if (emergency && start_edge) state_nxt = saved_q;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, edge-detect history and registered outputs
    always_ff @(posedge CLK_50) begin
        if (CLR) begin
            state_q    <= S_IDLE;
            saved_q    <= S_IDLE;
            set_q      <= 8'h00;
            rem_q      <= 8'h00;
            seg_q      <= 8'd0;
            alm_q      <= 8'd0;
            add_q      <= 1'b1;
            start_q    <= 1'b1;
            forward    <= 1'b0;
            backward   <= 1'b0;
            off        <= 1'b1;
            alarm      <= 1'b0;
            busy       <= 1'b0;
            remain_bcd <= 8'h00;
        end else begin
            state_q    <= state_nxt;
            saved_q    <= saved_nxt;
            set_q      <= set_nxt;
            rem_q      <= rem_nxt;
            seg_q      <= seg_nxt;
            alm_q      <= alm_nxt;
            add_q      <= add;
            start_q    <= start;
            forward    <= (state_nxt == S_FWD);
            backward   <= (state_nxt == S_BWD);
            off        <= !((state_nxt == S_FWD) || (state_nxt == S_BWD));
            alarm      <= (state_nxt == S_DONE) || (state_nxt == S_HALT);
            busy       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            remain_bcd <= (state_nxt == S_IDLE) ? set_nxt :
                          (state_nxt == S_DONE) ? 8'h00 : rem_nxt;
        end
    end

endmodule

// File: tb/tb_wash_cycle_scheduler.sv
// Bench for wash_cycle_scheduler: directed scenarios with literal expectations
// plus randomized stimulus, all checked each cycle against a tick-count model.
module tb_wash_cycle_scheduler;

    localparam int RUN_T   = 3;
    localparam int PAUSE_T = 1;
    localparam int ALARM_T = 2;
    localparam int PERIOD  = 2 * (RUN_T + PAUSE_T);

    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_HALT = 3;

    logic       clk = 1'b0;
    logic       clr = 1'b1, tick = 1'b0, add = 1'b0, start = 1'b0, emergency = 1'b1;
    logic       forward, backward, off, alarm, busy;
    logic [7:0] remain_bcd;

    int checks = 0;
    int errors = 0;

    wash_cycle_scheduler #(.RUN_T(RUN_T), .PAUSE_T(PAUSE_T), .ALARM_T(ALARM_T)) dut (
        .CLK_50(clk), .CLR(clr), .tick(tick), .add(add), .start(start),
        .emergency(emergency), .forward(forward), .backward(backward), .off(off),
        .alarm(alarm), .remain_bcd(remain_bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode, set/remaining as integers, and elapsed run ticks
    // from which the motor direction follows by position within one period.
    int m_mode = M_IDLE, m_set = 0, m_rem = 0, m_el = 0, m_alm = 0;
    bit m_pa = 1'b1, m_ps = 1'b1, started = 1'b0;

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    always @(posedge clk) begin
        bit ae, se;
        ae = add && !m_pa;
        se = start && !m_ps;
        m_pa = add;
        m_ps = start;
        started = 1'b1;
        if (clr) begin
            m_mode = M_IDLE; m_set = 0; m_rem = 0; m_el = 0; m_alm = 0;
            m_pa = 1'b1; m_ps = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (se && emergency && m_set != 0) begin
                        m_mode = M_RUN; m_rem = m_set; m_el = 0;
                    end
                    if (ae) m_set = (m_set + 1) % 100;
                end
                M_RUN: begin
                    if (!emergency) m_mode = M_HALT;
                    else if (tick) begin
                        m_rem--; m_el++;
                        if (m_rem == 0) begin m_mode = M_DONE; m_alm = 0; end
                    end
                end
                M_DONE: if (tick) begin
                    m_alm++;
                    if (m_alm == ALARM_T) m_mode = M_IDLE;
                end
                default: if (emergency && se) m_mode = M_RUN;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        if (started) begin
            int  pos;
            bit  ef, eb;
            pos = m_el % PERIOD;
            ef = (m_mode == M_RUN) && (pos < RUN_T);
            eb = (m_mode == M_RUN) && (pos >= RUN_T + PAUSE_T) && (pos < 2 * RUN_T + PAUSE_T);
            chk("model_forward",  {7'd0, forward},  {7'd0, ef});
            chk("model_backward", {7'd0, backward}, {7'd0, eb});
            chk("model_off",      {7'd0, off},      {7'd0, !(ef || eb)});
            chk("model_alarm",    {7'd0, alarm},    {7'd0, (m_mode == M_DONE) || (m_mode == M_HALT)});
            chk("model_busy",     {7'd0, busy},     {7'd0, (m_mode == M_RUN) || (m_mode == M_HALT)});
            chk("model_remain",   remain_bcd,
                (m_mode == M_IDLE) ? to_bcd(m_set) : (m_mode == M_DONE) ? 8'h00 : to_bcd(m_rem));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr = 1'b1; step(); step();
        clr = 1'b0; step();
    endtask

    task automatic press_add(input int n);
        for (int i = 0; i < n; i++) begin
            add = 1'b1; step(); add = 1'b0; step();
        end
    endtask

    task automatic press_start();
        start = 1'b1; step(); start = 1'b0; step();
    endtask

    task automatic give_tick();
        tick = 1'b1; step(); tick = 1'b0; step();
    endtask

    initial begin
        step();
        do_reset();
        chk("rst_off", {7'd0, off}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_alarm", {7'd0, alarm}, 8'd0);
        chk("rst_remain", remain_bcd, 8'h00);

        // Short cycle: set 3, start, complete, alarm then back to IDLE
        press_add(3);
        chk("set3_remain", remain_bcd, 8'h03);
        start = 1'b1; step();
        chk("start_fwd", {7'd0, forward}, 8'd1);
        start = 1'b0; step();
        for (int i = 0; i < 3; i++) give_tick();
        chk("done_alarm", {7'd0, alarm}, 8'd1);
        chk("done_remain", remain_bcd, 8'h00);
        chk("done_off", {7'd0, off}, 8'd1);
        give_tick(); give_tick();
        chk("idle_alarm", {7'd0, alarm}, 8'd0);
        chk("idle_reload", remain_bcd, 8'h03);

        // Set 10: full forward/pause/backward/pause/forward pattern
        press_add(7);
        chk("set10_remain", remain_bcd, 8'h10);
        press_start();
        for (int k = 1; k <= 10; k++) begin
            give_tick();
            chk("seq_remain", remain_bcd, (k == 10) ? 8'h00 : to_bcd(10 - k));
            if (k == 3) chk("seq_p1_off", {7'd0, off}, 8'd1);
            if (k == 4) chk("seq_bwd", {7'd0, backward}, 8'd1);
            if (k == 8) chk("seq_fwd2", {7'd0, forward}, 8'd1);
        end
        chk("seq_done", {7'd0, alarm}, 8'd1);
        give_tick(); give_tick();

        // Wrap 99 -> 00 and refuse to start on zero
        do_reset();
        press_add(100);
        chk("wrap_remain", remain_bcd, 8'h00);
        press_start();
        chk("zero_start_busy", {7'd0, busy}, 8'd0);

        // Emergency in P1 with a simultaneous tick, then resume
        do_reset();
        press_add(8);
        press_start();
        for (int i = 0; i < 3; i++) give_tick();   // now in P1 at 05
        tick = 1'b1; emergency = 1'b0; step(); tick = 1'b0; step();
        chk("halt_alarm", {7'd0, alarm}, 8'd1);
        chk("halt_remain", remain_bcd, 8'h05);
        press_start();
        chk("halt_hold", {7'd0, alarm}, 8'd1);
        emergency = 1'b1; step();
        press_start();
        chk("resume_alarm", {7'd0, alarm}, 8'd0);
        chk("resume_off", {7'd0, off}, 8'd1);
        give_tick();
        chk("resume_bwd", {7'd0, backward}, 8'd1);
        chk("resume_remain", remain_bcd, 8'h04);

        // Reset mid-BWD with add held across release
        add = 1'b1; clr = 1'b1; step();
        clr = 1'b0; step();
        chk("clr_busy", {7'd0, busy}, 8'd0);
        chk("clr_off", {7'd0, off}, 8'd1);
        add = 1'b0; step();
        chk("clr_no_add", remain_bcd, 8'h00);

        // Randomized traffic checked by the model process
        for (int c = 0; c < 4000; c++) begin
            tick      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) add = ~add;
            if ($urandom_range(0, 7) == 0) start = ~start;
            if ($urandom_range(0, 29) == 0) emergency = ~emergency;
            clr       = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
